// File: rtl/mem_arbiter_prio.sv
// mem_arbiter_prio: N-master to 1-slave memory request arbiter with in-order response routing.
//
// Optional build macro: MEM_ARB_STARVE_GUARD_EN adds per-master aging counters; a master
// that has waited STARVE_LIMIT cycles overrides normal selection (lowest index on ties).
//
// Ports:
//   clk, rst       clock and synchronous active-high reset
//   m_req_valid    per-master request valid
//   m_req_ready    per-master request ready (only the granted master sees ready)
//   m_req_data     per-master payloads, master i at [i*REQ_W +: REQ_W]
//   m_resp_valid   per-master response valid (only the master at the queue head)
//   m_resp_ready   per-master response ready
//   m_resp_data    response payload broadcast to all masters
//   s_req_*        request channel to the slave
//   s_resp_*       response channel from the slave
//   proto_err      sticky flag: slave response arrived with nothing outstanding
module mem_arbiter_prio #(
    parameter int CNT          = 2,
    parameter int REQ_W        = 69,
    parameter int RESP_W       = 32,
    parameter int QUEUE_DEPTH  = 2,
    parameter int RR_MODE      = 0,
    parameter int PIPE         = 1,
    parameter int STARVE_LIMIT = 15
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [CNT-1:0]         m_req_valid,
    output logic [CNT-1:0]         m_req_ready,
    input  logic [CNT*REQ_W-1:0]   m_req_data,
    output logic [CNT-1:0]         m_resp_valid,
    input  logic [CNT-1:0]         m_resp_ready,
    output logic [RESP_W-1:0]      m_resp_data,
    output logic                   s_req_valid,
    input  logic                   s_req_ready,
    output logic [REQ_W-1:0]       s_req_data,
    input  logic                   s_resp_valid,
    output logic                   s_resp_ready,
    input  logic [RESP_W-1:0]      s_resp_data,
    output logic                   proto_err
);
    localparam int IW = (CNT > 1) ? $clog2(CNT) : 1;
    localparam int PW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int CW = $clog2(QUEUE_DEPTH + 1);

    logic [REQ_W-1:0] req_arr [CNT];
    logic [IW-1:0]    q_mem [QUEUE_DEPTH];
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic [CW-1:0]    count;
    logic [IW-1:0]    head_idx;
    logic [IW-1:0]    ptr;
    logic [IW-1:0]    rr_base;
    logic [IW-1:0]    cand;
    logic [IW-1:0]    sel;
    logic [IW-1:0]    pick;
    logic [IW-1:0]    grant;
    logic [IW-1:0]    lock_idx;
    logic             lock_q;
    logic             full;
    logic             empty;
    logic             slot_free;
    logic             req_fire;
    logic             resp_fire;

    for (genvar i = 0; i < CNT; i++) begin : g_unpack
        assign req_arr[i] = m_req_data[i*REQ_W +: REQ_W];
    end

    // Normal selection: scan CNT candidates starting at rr_base (0 in fixed mode).
    // Scanning downward and letting the last hit win yields the first valid master
    // at or after the base, wrapping upward.
    assign rr_base = (RR_MODE != 0) ? ptr : '0;

    always_comb begin
        sel  = '0;
        cand = '0;
        for (int k = CNT - 1; k >= 0; k--) begin
            cand = IW'((int'(rr_base) + k) % CNT);
            if (m_req_valid[cand]) sel = cand;
        end
    end

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [SW-1:0]  age [CNT];
    logic [CNT-1:0] aged;
    logic           starved;
    logic [IW-1:0]  starve_idx;
    logic [IW-1:0]  s_cand;

    for (genvar i = 0; i < CNT; i++) begin : g_age
        // Counts cycles spent waiting; a fire clears it, otherwise it saturates.
        always_ff @(posedge clk) begin
            if (rst) begin
                age[i] <= '0;
            end else if (m_req_valid[i] && m_req_ready[i]) begin
                age[i] <= '0;
            end else if (m_req_valid[i] && age[i] != SW'(STARVE_LIMIT)) begin
                age[i] <= age[i] + 1'b1;
            end
        end
        assign aged[i] = age[i] == SW'(STARVE_LIMIT);
    end

    always_comb begin
        starved    = 1'b0;
        starve_idx = '0;
        s_cand     = '0;
        for (int k = CNT - 1; k >= 0; k--) begin
            s_cand = IW'(k);
            if (aged[s_cand]) begin
                starved    = 1'b1;
                starve_idx = s_cand;
            end
        end
    end

    assign pick = starved ? starve_idx : sel;
`else
    logic unused_starve;

    assign unused_starve = (STARVE_LIMIT == 0);
    assign pick          = sel;
`endif

    // A stalled request keeps its grant so the slave sees a stable payload.
    assign grant = lock_q ? lock_idx : pick;

    // Outstanding-transaction queue status and response routing.
    assign full         = count == CW'(QUEUE_DEPTH);
    assign empty        = count == '0;
    assign head_idx     = q_mem[head];
    assign s_resp_ready = !empty && m_resp_ready[head_idx];
    assign resp_fire    = s_resp_valid && s_resp_ready;
    assign m_resp_data  = s_resp_data;

    // With PIPE set, a full queue still accepts a request when the head leaves this cycle.
    assign slot_free   = !full || (PIPE != 0 && resp_fire);
    assign s_req_valid = (|m_req_valid) && slot_free;
    assign s_req_data  = req_arr[grant];
    assign req_fire    = s_req_valid && s_req_ready;

    for (genvar i = 0; i < CNT; i++) begin : g_ports
        assign m_req_ready[i]  = s_req_valid && s_req_ready && grant == IW'(i);
        assign m_resp_valid[i] = !empty && s_resp_valid && head_idx == IW'(i);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            ptr       <= '0;
            lock_q    <= 1'b0;
            lock_idx  <= '0;
            proto_err <= 1'b0;
        end else begin
            if (req_fire) begin
                tail <= (tail == PW'(QUEUE_DEPTH - 1)) ? '0 : tail + 1'b1;
                ptr  <= (grant == IW'(CNT - 1)) ? '0 : grant + 1'b1;
            end
            if (resp_fire) head <= (head == PW'(QUEUE_DEPTH - 1)) ? '0 : head + 1'b1;
            if (req_fire != resp_fire) count <= req_fire ? count + 1'b1 : count - 1'b1;
            lock_q <= s_req_valid && !s_req_ready;
            if (s_req_valid && !s_req_ready) lock_idx <= grant;
            if (s_resp_valid && empty) proto_err <= 1'b1;
        end
    end

    // Queue storage needs no reset: entries are only read between push and pop.
    always_ff @(posedge clk) begin
        if (req_fire) q_mem[tail] <= grant;
    end
endmodule

// File: tb/tb_mem_arbiter_prio.sv
// tb_mem_arbiter_prio: bench for mem_arbiter_prio (fixed/PIPE=0 instance A, round-robin/PIPE=1 instance B).
module tb_mem_arbiter_prio;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [1:0]  a_mv, a_mr, a_rv, a_rr;
    logic [23:0] a_md;
    logic [7:0]  a_rd, a_srd;
    logic        a_sv, a_sr, a_srv, a_srr, a_err;
    logic [11:0] a_sd;

    logic [2:0]  b_mv, b_mr, b_rv, b_rr;
    logic [35:0] b_md;
    logic [7:0]  b_rd, b_srd;
    logic        b_sv, b_sr, b_srv, b_srr, b_err;
    logic [11:0] b_sd;

    mem_arbiter_prio #(.CNT(2), .REQ_W(12), .RESP_W(8), .QUEUE_DEPTH(2), .RR_MODE(0), .PIPE(0), .STARVE_LIMIT(3)) u_a (
        .clk(clk), .rst(rst),
        .m_req_valid(a_mv), .m_req_ready(a_mr), .m_req_data(a_md),
        .m_resp_valid(a_rv), .m_resp_ready(a_rr), .m_resp_data(a_rd),
        .s_req_valid(a_sv), .s_req_ready(a_sr), .s_req_data(a_sd),
        .s_resp_valid(a_srv), .s_resp_ready(a_srr), .s_resp_data(a_srd),
        .proto_err(a_err)
    );

    mem_arbiter_prio #(.CNT(3), .REQ_W(12), .RESP_W(8), .QUEUE_DEPTH(2), .RR_MODE(1), .PIPE(1), .STARVE_LIMIT(3)) u_b (
        .clk(clk), .rst(rst),
        .m_req_valid(b_mv), .m_req_ready(b_mr), .m_req_data(b_md),
        .m_resp_valid(b_rv), .m_resp_ready(b_rr), .m_resp_data(b_rd),
        .s_req_valid(b_sv), .s_req_ready(b_sr), .s_req_data(b_sd),
        .s_resp_valid(b_srv), .s_resp_ready(b_srr), .s_resp_data(b_srd),
        .proto_err(b_err)
    );

    typedef struct {
        logic [1:0]  mv;
        logic [11:0] d0, d1;
        logic        sr, srv;
        logic [7:0]  srd;
        logic [1:0]  mrr;
        logic        esv;
        logic [11:0] esd;
        logic [1:0]  emr, erv;
        logic        esrr, eerr;
    } vec_t;

    typedef struct {
        int          idx;
        logic [11:0] data;
    } sb_t;

    vec_t tbl [11];
    sb_t  sb_q [$];
    int   n_chk = 0;
    int   n_fail = 0;
    logic       a_pend_v = 1'b0, b_pend_v = 1'b0;
    logic [7:0] a_pend_d = '0, b_pend_d = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        n_chk++;
        n_fail++;
        $display("FAIL %s: got response, expected none outstanding in scoreboard", nm);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        a_mv = '0; a_md = '0; a_rr = '0; a_sr = 1'b0; a_srv = 1'b0; a_srd = '0;
        b_mv = '0; b_md = '0; b_rr = '0; b_sr = 1'b0; b_srv = 1'b0; b_srd = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        a_pend_v = 1'b0; b_pend_v = 1'b0;
        sb_q.delete();
        #1;
    endtask

    task automatic a_apply(input logic [1:0] mv, input logic [11:0] d0, input logic [11:0] d1,
                           input logic sr, input logic srv, input logic [7:0] srd, input logic [1:0] mrr);
        @(posedge clk); #1;
        a_mv = mv; a_md = {d1, d0}; a_sr = sr; a_srv = srv; a_srd = srd; a_rr = mrr;
        #1;
    endtask

    task automatic b_apply(input logic [2:0] mv, input logic [11:0] base,
                           input logic sr, input logic srv, input logic [7:0] srd, input logic [2:0] mrr);
        @(posedge clk); #1;
        b_mv = mv; b_md = {base + 12'h022, base + 12'h011, base};
        b_sr = sr; b_srv = srv; b_srd = srd; b_rr = mrr;
        #1;
    endtask

    // One cycle on A with an always-ready slave that answers each request one cycle later
    // with (payload[7:0] ^ 0x5A); eidx is the master expected to win (-1: none).
    task automatic a_sb(input logic [1:0] mv, input logic [11:0] base, input int eidx);
        logic [11:0] pl;
        sb_t e;
        @(posedge clk); #1;
        a_mv = mv; a_md = {base + 12'h011, base}; a_sr = 1'b1; a_rr = 2'b11;
        a_srv = a_pend_v; a_srd = a_pend_d;
        #1;
        if (a_pend_v) begin
            if (sb_q.size() == 0) fail_now("a_sb_underflow");
            else begin
                e = sb_q.pop_front();
                chk("a_resp_route", 32'(a_rv), 32'(1) << e.idx);
                chk("a_resp_data", 32'(a_rd), 32'(e.data[7:0] ^ 8'h5A));
            end
        end else chk("a_resp_idle", 32'(a_rv), 32'(0));
        chk("a_req_valid", 32'(a_sv), 32'(eidx >= 0));
        if (eidx >= 0) begin
            pl = (eidx == 1) ? base + 12'h011 : base;
            chk("a_req_data", 32'(a_sd), 32'(pl));
            chk("a_req_ready", 32'(a_mr), 32'(1) << eidx);
            sb_q.push_back('{idx: eidx, data: pl});
        end
        a_pend_v = a_sv && a_sr;
        a_pend_d = a_sd[7:0] ^ 8'h5A;
    endtask

    task automatic b_sb(input logic [2:0] mv, input logic [11:0] base, input int eidx);
        logic [11:0] pl;
        sb_t e;
        @(posedge clk); #1;
        b_mv = mv; b_md = {base + 12'h022, base + 12'h011, base}; b_sr = 1'b1; b_rr = 3'b111;
        b_srv = b_pend_v; b_srd = b_pend_d;
        #1;
        if (b_pend_v) begin
            if (sb_q.size() == 0) fail_now("b_sb_underflow");
            else begin
                e = sb_q.pop_front();
                chk("b_resp_route", 32'(b_rv), 32'(1) << e.idx);
                chk("b_resp_data", 32'(b_rd), 32'(e.data[7:0] ^ 8'h5A));
            end
        end else chk("b_resp_idle", 32'(b_rv), 32'(0));
        chk("b_req_valid", 32'(b_sv), 32'(eidx >= 0));
        if (eidx >= 0) begin
            pl = base + 12'(eidx * 17);
            chk("b_req_data", 32'(b_sd), 32'(pl));
            chk("b_req_ready", 32'(b_mr), 32'(1) << eidx);
            sb_q.push_back('{idx: eidx, data: pl});
        end
        b_pend_v = b_sv && b_sr;
        b_pend_d = b_sd[7:0] ^ 8'h5A;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected test completion");
        $fatal(1);
    end

    initial begin
        logic [2:0] rr_mv [13];
        int         rr_g  [13];
        int         g3;

        //            mv     d0       d1       sr    srv   srd    mrr    esv   esd      emr    erv    esrr  eerr
        tbl[0]  = '{2'b01, 12'h111, 12'h000, 1'b1, 1'b0, 8'h00, 2'b11, 1'b1, 12'h111, 2'b01, 2'b00, 1'b0, 1'b0};
        tbl[1]  = '{2'b11, 12'h113, 12'h222, 1'b1, 1'b1, 8'hA0, 2'b11, 1'b1, 12'h113, 2'b01, 2'b01, 1'b1, 1'b0};
        tbl[2]  = '{2'b10, 12'h113, 12'h222, 1'b1, 1'b0, 8'h00, 2'b11, 1'b1, 12'h222, 2'b10, 2'b00, 1'b1, 1'b0};
        tbl[3]  = '{2'b11, 12'h113, 12'h222, 1'b1, 1'b0, 8'h00, 2'b11, 1'b0, 12'h000, 2'b00, 2'b00, 1'b1, 1'b0};
        tbl[4]  = '{2'b11, 12'h113, 12'h222, 1'b1, 1'b1, 8'hA1, 2'b11, 1'b0, 12'h000, 2'b00, 2'b01, 1'b1, 1'b0};
        tbl[5]  = '{2'b01, 12'h115, 12'h222, 1'b0, 1'b1, 8'hA2, 2'b01, 1'b1, 12'h115, 2'b00, 2'b10, 1'b0, 1'b0};
        tbl[6]  = '{2'b11, 12'h115, 12'h223, 1'b1, 1'b1, 8'hA3, 2'b11, 1'b1, 12'h115, 2'b01, 2'b10, 1'b1, 1'b0};
        tbl[7]  = '{2'b00, 12'h115, 12'h223, 1'b1, 1'b1, 8'hA4, 2'b01, 1'b0, 12'h000, 2'b00, 2'b01, 1'b1, 1'b0};
        tbl[8]  = '{2'b00, 12'h000, 12'h000, 1'b1, 1'b1, 8'hA5, 2'b11, 1'b0, 12'h000, 2'b00, 2'b00, 1'b0, 1'b0};
        tbl[9]  = '{2'b00, 12'h000, 12'h000, 1'b1, 1'b0, 8'h00, 2'b11, 1'b0, 12'h000, 2'b00, 2'b00, 1'b0, 1'b1};
        tbl[10] = '{2'b10, 12'h000, 12'h224, 1'b1, 1'b0, 8'h00, 2'b11, 1'b1, 12'h224, 2'b10, 2'b00, 1'b0, 1'b1};

        rr_mv = '{3'b111, 3'b111, 3'b111, 3'b111, 3'b111, 3'b111,
                  3'b110, 3'b101, 3'b010, 3'b011, 3'b100, 3'b000, 3'b000};
        rr_g  = '{0, 1, 2, 0, 1, 2, 1, 2, 1, 0, 2, -1, -1};

        do_reset();
        chk("rst a_s_req_valid", 32'(a_sv), 32'(0));
        chk("rst a_m_req_ready", 32'(a_mr), 32'(0));
        chk("rst a_m_resp_valid", 32'(a_rv), 32'(0));
        chk("rst a_s_resp_ready", 32'(a_srr), 32'(0));
        chk("rst a_proto_err", 32'(a_err), 32'(0));
        chk("rst b_s_req_valid", 32'(b_sv), 32'(0));
        chk("rst b_proto_err", 32'(b_err), 32'(0));

        // Fixed priority: m0 wins three cycles, m1 fires once m0 drops.
        a_sb(2'b11, 12'h010, 0);
        a_sb(2'b11, 12'h020, 0);
        a_sb(2'b11, 12'h030, 0);
        a_sb(2'b10, 12'h040, 1);
        a_sb(2'b00, 12'h050, -1);
        a_sb(2'b00, 12'h060, -1);
        chk("a_sb_drained", 32'(sb_q.size()), 32'(0));

        // Lock: m1 stalled by the slave keeps the grant when m0 raises valid.
        a_apply(2'b10, 12'h0A1, 12'h0B1, 1'b0, 1'b0, 8'h00, 2'b11);
        chk("lock c1 s_req_valid", 32'(a_sv), 32'(1));
        chk("lock c1 s_req_data", 32'(a_sd), 32'(12'h0B1));
        chk("lock c1 m_req_ready", 32'(a_mr), 32'(0));
        for (int c = 2; c <= 4; c++) begin
            a_apply(2'b11, 12'h0A1, 12'h0B1, 1'b0, 1'b0, 8'h00, 2'b11);
            chk($sformatf("lock c%0d s_req_data", c), 32'(a_sd), 32'(12'h0B1));
            chk($sformatf("lock c%0d m_req_ready", c), 32'(a_mr), 32'(0));
        end
        a_apply(2'b11, 12'h0A1, 12'h0B1, 1'b1, 1'b0, 8'h00, 2'b11);
        chk("lock c5 s_req_data", 32'(a_sd), 32'(12'h0B1));
        chk("lock c5 m_req_ready", 32'(a_mr), 32'(2'b10));
        a_apply(2'b01, 12'h0A1, 12'h0B1, 1'b1, 1'b0, 8'h00, 2'b11);
        chk("lock c6 s_req_data", 32'(a_sd), 32'(12'h0A1));
        chk("lock c6 m_req_ready", 32'(a_mr), 32'(2'b01));
        a_apply(2'b00, 12'h000, 12'h000, 1'b1, 1'b1, 8'h55, 2'b11);
        chk("lock drain1 m_resp_valid", 32'(a_rv), 32'(2'b10));
        chk("lock drain1 s_req_valid", 32'(a_sv), 32'(0));
        a_apply(2'b00, 12'h000, 12'h000, 1'b1, 1'b1, 8'h56, 2'b11);
        chk("lock drain2 m_resp_valid", 32'(a_rv), 32'(2'b01));
        a_apply(2'b00, 12'h000, 12'h000, 1'b1, 1'b0, 8'h00, 2'b11);
        chk("lock drain3 s_resp_ready", 32'(a_srr), 32'(0));

        // Vector table: PIPE=0 full blocking, head routing, response back-pressure, proto_err.
        for (int i = 0; i < 11; i++) begin
            a_apply(tbl[i].mv, tbl[i].d0, tbl[i].d1, tbl[i].sr, tbl[i].srv, tbl[i].srd, tbl[i].mrr);
            chk($sformatf("v%0d s_req_valid", i), 32'(a_sv), 32'(tbl[i].esv));
            if (tbl[i].esv) chk($sformatf("v%0d s_req_data", i), 32'(a_sd), 32'(tbl[i].esd));
            chk($sformatf("v%0d m_req_ready", i), 32'(a_mr), 32'(tbl[i].emr));
            chk($sformatf("v%0d m_resp_valid", i), 32'(a_rv), 32'(tbl[i].erv));
            chk($sformatf("v%0d s_resp_ready", i), 32'(a_srr), 32'(tbl[i].esrr));
            chk($sformatf("v%0d m_resp_data", i), 32'(a_rd), 32'(tbl[i].srd));
            chk($sformatf("v%0d proto_err", i), 32'(a_err), 32'(tbl[i].eerr));
        end

        // Reset with one request outstanding clears the flag; a late response re-raises it.
        do_reset();
        chk("rst2 proto_err", 32'(a_err), 32'(0));
        chk("rst2 s_resp_ready", 32'(a_srr), 32'(0));
        a_apply(2'b00, 12'h000, 12'h000, 1'b1, 1'b1, 8'hA6, 2'b11);
        chk("late s_resp_ready", 32'(a_srr), 32'(0));
        chk("late m_resp_valid", 32'(a_rv), 32'(0));
        chk("late proto_err same cycle", 32'(a_err), 32'(0));
        a_apply(2'b00, 12'h000, 12'h000, 1'b1, 1'b0, 8'h00, 2'b11);
        chk("late proto_err next", 32'(a_err), 32'(1));
        a_apply(2'b00, 12'h000, 12'h000, 1'b1, 1'b0, 8'h00, 2'b11);
        chk("late proto_err sticky", 32'(a_err), 32'(1));

        // Round-robin on B: 0,1,2,0,1,2 back to back, then sparse patterns with wrap.
        do_reset();
        for (int i = 0; i < 13; i++) b_sb(rr_mv[i], 12'h100 + 12'(i * 64), rr_g[i]);
        chk("b_sb_drained", 32'(sb_q.size()), 32'(0));

        // PIPE=1: with two outstanding, a new request fires only in the pop cycle.
        b_apply(3'b001, 12'h300, 1'b1, 1'b0, 8'h00, 3'b111);
        chk("pipe c0 m_req_ready", 32'(b_mr), 32'(3'b001));
        b_apply(3'b001, 12'h310, 1'b1, 1'b0, 8'h00, 3'b111);
        chk("pipe c1 m_req_ready", 32'(b_mr), 32'(3'b001));
        b_apply(3'b001, 12'h320, 1'b1, 1'b0, 8'h00, 3'b111);
        chk("pipe full s_req_valid", 32'(b_sv), 32'(0));
        chk("pipe full m_req_ready", 32'(b_mr), 32'(0));
        b_apply(3'b001, 12'h320, 1'b1, 1'b1, 8'h77, 3'b111);
        chk("pipe pop s_req_valid", 32'(b_sv), 32'(1));
        chk("pipe pop m_req_ready", 32'(b_mr), 32'(3'b001));
        chk("pipe pop m_resp_valid", 32'(b_rv), 32'(3'b001));
        chk("pipe pop m_resp_data", 32'(b_rd), 32'(8'h77));
        for (int c = 0; c < 2; c++) begin
            b_apply(3'b000, 12'h000, 1'b1, 1'b1, 8'h78, 3'b111);
            chk($sformatf("pipe drain%0d m_resp_valid", c), 32'(b_rv), 32'(3'b001));
        end
        b_apply(3'b000, 12'h000, 1'b1, 1'b0, 8'h00, 3'b111);
        chk("pipe empty s_resp_ready", 32'(b_srr), 32'(0));
        chk("pipe empty m_resp_valid", 32'(b_rv), 32'(0));
        chk("pipe b_proto_err", 32'(b_err), 32'(0));

        // Starvation guard (limit 3): m1 fires in its fourth waiting cycle when enabled.
        do_reset();
`ifdef MEM_ARB_STARVE_GUARD_EN
        g3 = 1;
`else
        g3 = 0;
`endif
        a_sb(2'b11, 12'h100, 0);
        a_sb(2'b11, 12'h110, 0);
        a_sb(2'b11, 12'h120, 0);
        a_sb(2'b11, 12'h130, g3);
        a_sb(2'b01, 12'h140, 0);
        a_sb(2'b01, 12'h150, 0);
        a_sb(2'b00, 12'h160, -1);
        a_sb(2'b00, 12'h170, -1);
        chk("starve_sb_drained", 32'(sb_q.size()), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
